muller_c_hs_responder: RTL and testbench

//   Clocked four-phase (return-to-zero) handshake responder that sits at the output end of the

---
 rtl/muller_c_pkg.sv | 6 +
 rtl/muller_c_sync.sv | 16 +
 rtl/muller_c_hs_responder.sv | 82 ++++++++
 tb/tb_muller_c_hs_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muller_c_pkg.sv
// muller_c_pkg: shared types and constants for the C-element handshake responder.
package muller_c_pkg;
    typedef enum logic {HS_IDLE, HS_WAIT_LO} hs_state_t;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int XFER_CNT_W = 8;
endpackage

// File: rtl/muller_c_sync.sv
// muller_c_sync: multi-flop synchroniser for an asynchronous single-bit input.
module muller_c_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clock) begin
        if (!reset_n) chain <= '0;
        else chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/muller_c_hs_responder.sv
// muller_c_hs_responder: four-phase handshake responder with a one-entry valid/ready
// output buffer, stall timeout flag and transfer counter.
module muller_c_hs_responder
    import muller_c_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  ack_o,
    output logic                  out_valid_o,
    output logic [DATA_W-1:0]     out_data_o,
    input  logic                  out_ready_i,
    output logic                  timeout_o,
    output logic [XFER_CNT_W-1:0] xfer_cnt_o
);
    localparam logic [TIMEOUT_W-1:0] STALL_MAX = '1;
    hs_state_t state, state_nxt;
    logic req_s, buf_free, capture, primed, armed;
    logic [SYNC_STAGES-1:0] prime;
    logic [TIMEOUT_W-1:0] stall_cnt, stall_nxt;

    muller_c_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (req_i),
        .q       (req_s)
    );

    assign buf_free = !out_valid_o | out_ready_i;
    assign primed   = prime[SYNC_STAGES-1];
    assign ack_o    = state == HS_WAIT_LO;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        stall_nxt = stall_cnt;
        if (state == HS_IDLE) begin
            if (req_s && armed && buf_free) begin
                capture   = 1'b1;
                state_nxt = HS_WAIT_LO;
                stall_nxt = '0;
            end
        end else if (!req_s) begin
            state_nxt = HS_IDLE;
        end else if (stall_cnt != STALL_MAX) begin
            stall_nxt = stall_cnt + 1'b1;
        end
    end

    // A low req only arms capture once the synchroniser holds genuine samples, so a req
    // left high across reset is not taken as a fresh request.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= HS_IDLE;
            prime       <= '0;
            armed       <= 1'b0;
            stall_cnt   <= '0;
            timeout_o   <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            xfer_cnt_o  <= '0;
        end else begin
            state     <= state_nxt;
            prime     <= {prime[SYNC_STAGES-2:0], 1'b1};
            armed     <= capture ? 1'b0 : armed | (primed & !req_s);
            stall_cnt <= stall_nxt;
            timeout_o <= timeout_o | (ack_o && stall_nxt == STALL_MAX);
            if (capture) begin
                out_data_o  <= data_i;
                out_valid_o <= 1'b1;
                xfer_cnt_o  <= xfer_cnt_o + 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_muller_c_hs_responder.sv
// tb_muller_c_hs_responder: directed self-checking bench for the handshake responder.
module tb_muller_c_hs_responder;
    logic       clock = 1'b0;
    logic       reset_n, req_i, out_ready_i;
    logic [3:0] data_i;
    logic       ack_o, out_valid_o, timeout_o;
    logic [3:0] out_data_o;
    logic [7:0] xfer_cnt_o;
    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    logic       sb_on = 1'b0;
    logic [3:0] exp_q[$];

    muller_c_hs_responder #(.DATA_W(4), .SYNC_STAGES(2), .TIMEOUT_W(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .data_i      (data_i),
        .ack_o       (ack_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .timeout_o   (timeout_o),
        .xfer_cnt_o  (xfer_cnt_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        for (int i = 0; i < 10 && ack_o !== lvl; i++) step(1);
        chk(tag, ack_o, lvl);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, ack_o, 0);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_data"}, out_data_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_cnt"}, xfer_cnt_o, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_i   = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(3);
    endtask

    // with out_ready_i high each word is valid for exactly one cycle
    always @(negedge clock) begin
        if (sb_on && out_valid_o && out_ready_i) begin
            chk("t5_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("t5_word", out_data_o, exp_q.pop_front());
            rx_cnt++;
        end
    end

    initial begin
        reset_n = 1'b0; req_i = 1'b0; data_i = '0; out_ready_i = 1'b0;
        step(2);
        chk_all_zero("reset");
        reset_n = 1'b1;
        step(3);

        req_i = 1'b1; data_i = 4'b0110;
        step(2);
        chk("t1_ack_early", ack_o, 0);
        step(1);
        chk("t1_ack", ack_o, 1);
        chk("t1_valid", out_valid_o, 1);
        chk("t1_data", out_data_o, 4'h6);
        chk("t1_cnt", xfer_cnt_o, 1);
        data_i = 4'h9; req_i = 1'b0;
        step(2);
        chk("t1_ack_hold", ack_o, 1);
        step(1);
        chk("t1_ack_fall", ack_o, 0);
        chk("t1_data_hold", out_data_o, 4'h6);

        req_i = 1'b1; data_i = 4'hA;
        step(6);
        chk("t2_withheld", ack_o, 0);
        chk("t2_old_data", out_data_o, 4'h6);
        chk("t2_cnt_hold", xfer_cnt_o, 1);
        out_ready_i = 1'b1;
        step(1);
        chk("t2_ack", ack_o, 1);
        chk("t2_valid", out_valid_o, 1);
        chk("t2_data", out_data_o, 4'hA);
        chk("t2_cnt", xfer_cnt_o, 2);
        req_i = 1'b0;
        step(1);
        chk("t2_drain", out_valid_o, 0);
        chk("t2_drain_data", out_data_o, 4'hA);
        out_ready_i = 1'b0;
        step(2);
        chk("t2_ack_fall", ack_o, 0);

        req_i = 1'b1; data_i = 4'h3;
        wait_ack(1, "t3_ack1");
        req_i = 1'b0;
        wait_ack(0, "t3_ack1_fall");
        req_i = 1'b1; data_i = 4'hC;
        step(2);
        chk("t3_hold", out_valid_o, 1);
        out_ready_i = 1'b1;
        step(1);
        chk("t3_ack", ack_o, 1);
        chk("t3_valid", out_valid_o, 1);
        chk("t3_data", out_data_o, 4'hC);
        chk("t3_cnt", xfer_cnt_o, 4);
        out_ready_i = 1'b0; req_i = 1'b0;
        wait_ack(0, "t3_ack_fall");

        do_reset();
        out_ready_i = 1'b1; req_i = 1'b1; data_i = 4'h5;
        step(3);
        chk("t4_ack", ack_o, 1);
        step(6);
        chk("t4_no_timeout", timeout_o, 0);
        step(1);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_ack_held", ack_o, 1);
        req_i = 1'b0;
        step(3);
        chk("t4_ack_fall", ack_o, 0);
        chk("t4_sticky", timeout_o, 1);

        req_i = 1'b1; data_i = 4'h7;
        wait_ack(1, "t6_ack");
        reset_n = 1'b0;
        step(1);
        chk_all_zero("t6_reset");
        reset_n = 1'b1;
        step(6);
        chk("t6_no_capture", ack_o, 0);
        chk("t6_no_valid", out_valid_o, 0);
        req_i = 1'b0;
        step(4);
        req_i = 1'b1; data_i = 4'hB;
        step(3);
        chk("t6_ack", ack_o, 1);
        chk("t6_data", out_data_o, 4'hB);
        chk("t6_cnt", xfer_cnt_o, 1);
        req_i = 1'b0;
        wait_ack(0, "t6_ack_fall");

        do_reset();
        out_ready_i = 1'b1;
        sb_on = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(4'(i));
            req_i = 1'b1; data_i = 4'(i);
            wait_ack(1, "t5_ack");
            req_i = 1'b0;
            wait_ack(0, "t5_ack_fall");
        end
        step(2);
        sb_on = 1'b0;
        chk("t5_rx", rx_cnt, 256);
        chk("t5_wrap", xfer_cnt_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
